// File: rtl/a8_pkg.sv
// Shared types and A8 bus timing constants for the cycle sequencer.
package a8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_REQ
  } seq_state_t;

  localparam int unsigned A8_CYCLE_NS        = 558;
  localparam int unsigned A8_ADDR_STROBE_NS  = 177;
  localparam int unsigned A8_WRITE_STROBE_NS = 422;
  localparam int unsigned A8_READ_STROBE_NS  = 486;
  localparam int unsigned CLK_PERIOD_NS      = 5;

  // Value returned on the A8 bus when no valid read data is available.
  localparam logic [7:0] A8_FLOAT_DATA = 8'hFF;

  function automatic logic win_hit(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/a8_cycle_sequencer_if.sv
// Internal register-bus request/response channel between the sequencer and the register file.
interface a8_cycle_sequencer_if;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/a8_sat_counter.sv
// 8-bit event counter that sticks at 8'hFF; cleared only by synchronous reset.
module a8_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/a8_cycle_sequencer.sv
// Runs one register-bus handshake per A8 access to the cartridge window and drives/captures A8 data.
// One FSM; a single counter serves as response timeout and as data-hold timer after the cycle ends.
module a8_cycle_sequencer
  import a8_pkg::*;
#(
  parameter logic [15:0] WIN_BASE    = 16'hD100,
  parameter logic [15:0] WIN_MASK    = 16'hFF00,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned RSP_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a8_addr_strobe,
  input  logic                        a8_write_strobe,
  input  logic                        a8_read_strobe,
  input  logic                        a8_clk_falling,
  input  logic [15:0]                 a8_addr,
  input  logic                        a8_rw_n,
  input  logic [7:0]                  a8_data_in,
  output logic [7:0]                  a8_data_out,
  output logic                        a8_data_oe,
  a8_cycle_sequencer_if.master        rbus,
  output logic [7:0]                  err_late,
  output logic [7:0]                  err_overrun
);

  localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES);

  seq_state_t state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       req_valid_q, req_valid_d;
  logic       req_write_q, req_write_d;
  logic [7:0] data_out_q, data_out_d;
  logic       oe_q, oe_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold_q, hold_d;
  logic       late_inc, ovr_inc;
  logic       tmo;

  assign tmo = (cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    data_out_d  = data_out_q;
    oe_d        = oe_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    late_inc    = 1'b0;
    ovr_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        oe_d   = 1'b0;
        hold_d = 1'b0;
        if (a8_addr_strobe && win_hit(a8_addr, WIN_BASE, WIN_MASK)) begin
          addr_d = a8_addr[7:0];
          if (a8_rw_n) begin
            req_valid_d = 1'b1;
            req_write_d = 1'b0;
            cnt_d       = '0;
            state_d     = RD_REQ;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end

      RD_REQ, RD_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if ((state_q == RD_REQ) && rbus.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = RD_WAIT;
        end
        // A response sampled with the read strobe still counts as on time.
        if (rbus.rsp_valid && ((state_q == RD_WAIT) || rbus.req_ready)) begin
          data_out_d  = rbus.rsp_rdata;
          req_valid_d = 1'b0;
          oe_d        = a8_read_strobe;
          state_d     = RD_DRIVE;
        end else if (a8_read_strobe) begin
          data_out_d  = A8_FLOAT_DATA;
          req_valid_d = 1'b0;
          late_inc    = 1'b1;
          oe_d        = 1'b1;
          state_d     = RD_DRIVE;
        end else if (tmo) begin
          data_out_d  = A8_FLOAT_DATA;
          req_valid_d = 1'b0;
          state_d     = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        if (a8_read_strobe) begin
          oe_d = 1'b1;
        end
        if (hold_q) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            oe_d    = 1'b0;
            hold_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (a8_clk_falling) begin
          cnt_d  = HOLD_LD;
          hold_d = 1'b1;
        end
      end

      WR_WAIT: begin
        if (a8_write_strobe) begin
          wdata_d     = a8_data_in;
          req_valid_d = 1'b1;
          req_write_d = 1'b1;
          cnt_d       = '0;
          state_d     = WR_REQ;
        end else if (a8_clk_falling) begin
          state_d = IDLE;
        end
      end

      WR_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // A new access cannot start until the pending write has drained.
        if (a8_addr_strobe) begin
          ovr_inc = 1'b1;
        end
        if (rbus.req_ready || tmo) begin
          req_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
        oe_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      data_out_q  <= '0;
      oe_q        <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      data_out_q  <= data_out_d;
      oe_q        <= oe_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
    end
  end

  assign rbus.req_valid = req_valid_q;
  assign rbus.req_write = req_write_q;
  assign rbus.req_addr  = addr_q;
  assign rbus.req_wdata = wdata_q;
  assign a8_data_out    = data_out_q;
  assign a8_data_oe     = oe_q;

  a8_sat_counter u_err_late (
    .clk (clk),
    .rst (rst),
    .inc (late_inc),
    .cnt (err_late)
  );

  a8_sat_counter u_err_overrun (
    .clk (clk),
    .rst (rst),
    .inc (ovr_inc),
    .cnt (err_overrun)
  );

endmodule

// File: tb/tb_a8_cycle_sequencer.sv
// Scoreboard bench for a8_cycle_sequencer: expected requests and read data are queued as stimulus
// is driven and compared when the handshake / output-enable rising edge is observed.
module tb_a8_cycle_sequencer;
  import a8_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a8_addr_strobe = 1'b0;
  logic        a8_write_strobe = 1'b0;
  logic        a8_read_strobe = 1'b0;
  logic        a8_clk_falling = 1'b0;
  logic [15:0] a8_addr = '0;
  logic        a8_rw_n = 1'b1;
  logic [7:0]  a8_data_in = '0;
  logic [7:0]  a8_data_out;
  logic        a8_data_oe;
  logic [7:0]  err_late;
  logic [7:0]  err_overrun;

  a8_cycle_sequencer_if rbus ();

  a8_cycle_sequencer #(
    .WIN_BASE    (16'hD100),
    .WIN_MASK    (16'hFF00),
    .HOLD_CYCLES (4),
    .RSP_TIMEOUT (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .a8_addr_strobe  (a8_addr_strobe),
    .a8_write_strobe (a8_write_strobe),
    .a8_read_strobe  (a8_read_strobe),
    .a8_clk_falling  (a8_clk_falling),
    .a8_addr         (a8_addr),
    .a8_rw_n         (a8_rw_n),
    .a8_data_in      (a8_data_in),
    .a8_data_out     (a8_data_out),
    .a8_data_oe      (a8_data_oe),
    .rbus            (rbus),
    .err_late        (err_late),
    .err_overrun     (err_overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int oe_cnt   = 0;
  int rv_cnt   = 0;
  logic oe_prev = 1'b0;
  logic [16:0] exp_req[$];
  logic [7:0]  exp_rd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe handshakes and output-enable rising edges away from the active edge.
  always @(negedge clk) begin
    if (a8_data_oe) oe_cnt++;
    if (rbus.req_valid) rv_cnt++;
    if (a8_data_oe && !oe_prev) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else chk("rd_data", {24'd0, a8_data_out}, {24'd0, exp_rd.pop_front()});
    end
    oe_prev = a8_data_oe;
    if (rbus.req_valid && rbus.req_ready) begin
      if (exp_req.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
      else chk("req_txn",
               {15'd0, rbus.req_write, rbus.req_addr, rbus.req_write ? rbus.req_wdata : 8'h00},
               {15'd0, exp_req.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_addr(input logic [15:0] a, input logic rw);
    a8_addr = a; a8_rw_n = rw; a8_addr_strobe = 1'b1;
    tick(1);
    a8_addr_strobe = 1'b0;
  endtask

  task automatic pulse_ws(input logic [7:0] d);
    a8_data_in = d; a8_write_strobe = 1'b1;
    tick(1);
    a8_write_strobe = 1'b0;
  endtask

  task automatic pulse_rs();
    a8_read_strobe = 1'b1;
    tick(1);
    a8_read_strobe = 1'b0;
  endtask

  task automatic pulse_fall();
    a8_clk_falling = 1'b1;
    tick(1);
    a8_clk_falling = 1'b0;
  endtask

  task automatic pulse_ready();
    rbus.req_ready = 1'b1;
    tick(1);
    rbus.req_ready = 1'b0;
  endtask

  task automatic pulse_rsp(input logic [7:0] d);
    rbus.rsp_valid = 1'b1; rbus.rsp_rdata = d;
    tick(1);
    rbus.rsp_valid = 1'b0;
  endtask

  initial begin
    rbus.req_ready = 1'b0;
    rbus.rsp_valid = 1'b0;
    rbus.rsp_rdata = '0;
    tick(3);
    chk("rst_req_valid", {31'd0, rbus.req_valid}, 32'd0);
    chk("rst_oe", {31'd0, a8_data_oe}, 32'd0);
    chk("rst_data_out", {24'd0, a8_data_out}, 32'd0);
    chk("rst_err_late", {24'd0, err_late}, 32'd0);
    chk("rst_err_overrun", {24'd0, err_overrun}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Read hit at D105, response 10 clk after request.
    pulse_addr(16'hD105, 1'b1);
    chk("rd1_req_valid", {31'd0, rbus.req_valid}, 32'd1);
    chk("rd1_req_write", {31'd0, rbus.req_write}, 32'd0);
    chk("rd1_req_addr", {24'd0, rbus.req_addr}, 32'h05);
    exp_req.push_back({1'b0, 8'h05, 8'h00});
    pulse_ready();
    chk("rd1_req_drop", {31'd0, rbus.req_valid}, 32'd0);
    tick(8);
    pulse_rsp(8'h5A);
    chk("rd1_data_out", {24'd0, a8_data_out}, 32'h5A);
    tick(5);
    chk("rd1_oe_before_rs", {31'd0, a8_data_oe}, 32'd0);
    exp_rd.push_back(8'h5A);
    pulse_rs();
    chk("rd1_oe_after_rs", {31'd0, a8_data_oe}, 32'd1);
    tick(10);
    pulse_fall();
    tick(3);
    chk("rd1_oe_hold3", {31'd0, a8_data_oe}, 32'd1);
    tick(1);
    chk("rd1_oe_hold4", {31'd0, a8_data_oe}, 32'd0);
    tick(2);

    // Late read: response withheld past the read strobe, then discarded.
    pulse_addr(16'hD142, 1'b1);
    exp_req.push_back({1'b0, 8'h42, 8'h00});
    pulse_ready();
    tick(3);
    exp_rd.push_back(A8_FLOAT_DATA);
    pulse_rs();
    chk("late_oe", {31'd0, a8_data_oe}, 32'd1);
    chk("late_data", {24'd0, a8_data_out}, 32'hFF);
    chk("late_err", {24'd0, err_late}, 32'd1);
    tick(2);
    pulse_rsp(8'h77);
    chk("late_discard", {24'd0, a8_data_out}, 32'hFF);
    pulse_fall();
    tick(5);
    chk("late_oe_off", {31'd0, a8_data_oe}, 32'd0);

    // Write D1F0 = C3 with ready three clocks late; back in IDLE afterwards.
    oe_cnt = 0;
    pulse_addr(16'hD1F0, 1'b0);
    chk("wr_no_early_req", {31'd0, rbus.req_valid}, 32'd0);
    tick(3);
    exp_req.push_back({1'b1, 8'hF0, 8'hC3});
    pulse_ws(8'hC3);
    chk("wr_req_valid", {31'd0, rbus.req_valid}, 32'd1);
    chk("wr_req_wdata", {24'd0, rbus.req_wdata}, 32'hC3);
    tick(2);
    pulse_ready();
    chk("wr_req_drop", {31'd0, rbus.req_valid}, 32'd0);
    pulse_fall();
    tick(4);
    chk("wr_no_oe", oe_cnt, 32'd0);

    // Misses: D200 read and 8000 write.
    oe_cnt = 0; rv_cnt = 0;
    pulse_addr(16'hD200, 1'b1);
    tick(4);
    pulse_rs();
    tick(3);
    pulse_fall();
    tick(6);
    pulse_addr(16'h8000, 1'b0);
    tick(3);
    pulse_ws(8'h12);
    tick(2);
    pulse_fall();
    tick(6);
    chk("miss_no_req", rv_cnt, 32'd0);
    chk("miss_no_oe", oe_cnt, 32'd0);

    // Overrun: write still pending when the next hit strobe arrives.
    oe_cnt = 0;
    pulse_addr(16'hD1AA, 1'b0);
    tick(2);
    exp_req.push_back({1'b1, 8'hAA, 8'h3C});
    pulse_ws(8'h3C);
    tick(2);
    pulse_fall();
    tick(8);
    pulse_addr(16'hD105, 1'b1);
    chk("ovr_err", {24'd0, err_overrun}, 32'd1);
    chk("ovr_still_pending", {31'd0, rbus.req_valid}, 32'd1);
    chk("ovr_addr_kept", {24'd0, rbus.req_addr}, 32'hAA);
    tick(3);
    pulse_rs();
    tick(2);
    pulse_ready();
    chk("ovr_done", {31'd0, rbus.req_valid}, 32'd0);
    pulse_fall();
    tick(6);
    chk("ovr_no_oe", oe_cnt, 32'd0);

    // Response and read strobe on the same clock: response wins.
    pulse_addr(16'hD1C0, 1'b1);
    exp_req.push_back({1'b0, 8'hC0, 8'h00});
    pulse_ready();
    tick(2);
    exp_rd.push_back(8'h99);
    rbus.rsp_valid = 1'b1; rbus.rsp_rdata = 8'h99; a8_read_strobe = 1'b1;
    tick(1);
    rbus.rsp_valid = 1'b0; a8_read_strobe = 1'b0;
    chk("sim_oe", {31'd0, a8_data_oe}, 32'd1);
    chk("sim_data", {24'd0, a8_data_out}, 32'h99);
    chk("sim_no_late", {24'd0, err_late}, 32'd1);
    pulse_fall();
    tick(5);

    // Timeout: request never accepted.
    rv_cnt = 0;
    pulse_addr(16'hD101, 1'b1);
    tick(70);
    chk("tmo_req_cycles", rv_cnt, 32'd64);
    chk("tmo_req_drop", {31'd0, rbus.req_valid}, 32'd0);
    exp_rd.push_back(A8_FLOAT_DATA);
    pulse_rs();
    chk("tmo_oe", {31'd0, a8_data_oe}, 32'd1);
    chk("tmo_no_late", {24'd0, err_late}, 32'd1);
    pulse_fall();
    tick(5);

    // Reset in the middle of RD_DRIVE.
    pulse_addr(16'hD108, 1'b1);
    exp_req.push_back({1'b0, 8'h08, 8'h00});
    pulse_ready();
    tick(2);
    exp_rd.push_back(8'h11);
    pulse_rsp(8'h11);
    tick(2);
    pulse_rs();
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_oe", {31'd0, a8_data_oe}, 32'd0);
    chk("mid_rst_req_valid", {31'd0, rbus.req_valid}, 32'd0);
    chk("mid_rst_err_late", {24'd0, err_late}, 32'd0);
    chk("mid_rst_err_overrun", {24'd0, err_overrun}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Repeated late reads saturate err_late.
    for (int i = 0; i < 300; i++) begin
      pulse_addr(16'hD100 | 16'(i & 255), 1'b1);
      tick(1);
      exp_rd.push_back(A8_FLOAT_DATA);
      pulse_rs();
      if (i == 0) chk("sat_first", {24'd0, err_late}, 32'd1);
      pulse_fall();
      tick(5);
    end
    chk("sat_err_late", {24'd0, err_late}, 32'hFF);
    chk("sat_idle_req", {31'd0, rbus.req_valid}, 32'd0);

    tick(2);
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
